// File: rtl/tft_raster_engine.sv
// TFT raster engine: panel power sequencing, programmable sync timing and
// per-frame shadowed rectangle compositing behind one aligned output register.
module tft_raster_engine #(
  parameter int H_ACTIVE  = 480,
  parameter int H_FP      = 2,
  parameter int H_SYNC    = 41,
  parameter int H_BP      = 2,
  parameter int V_ACTIVE  = 272,
  parameter int V_FP      = 2,
  parameter int V_SYNC    = 10,
  parameter int V_BP      = 4,
  parameter int X_BITS    = 10,
  parameter int Y_BITS    = 9,
  parameter int BPC       = 3,
  parameter int NUM_RECTS = 2,
  parameter int PWR_DELAY = 1000
) (
  input  logic                          tft_clk,
  input  logic                          rstb,
  input  logic                          enable,
  input  logic [NUM_RECTS-1:0]          rect_en,
  input  logic [NUM_RECTS*X_BITS-1:0]   rect_x,
  input  logic [NUM_RECTS*X_BITS-1:0]   rect_w,
  input  logic [NUM_RECTS*Y_BITS-1:0]   rect_y,
  input  logic [NUM_RECTS*Y_BITS-1:0]   rect_h,
  input  logic [NUM_RECTS*3*BPC-1:0]    rect_color,
  input  logic [3*BPC-1:0]              bg_color,
  output logic                          tft_vdd,
  output logic                          tft_display,
  output logic                          tft_backlight,
  output logic                          tft_data_ena,
  output logic                          tft_hsync_n,
  output logic                          tft_vsync_n,
  output logic [7:0]                    tft_red,
  output logic [7:0]                    tft_green,
  output logic [7:0]                    tft_blue,
  output logic [X_BITS-1:0]             x,
  output logic [Y_BITS-1:0]             y,
  output logic                          new_frame,
  output logic                          running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [X_BITS-1:0] H_LAST     = X_BITS'(H_TOTAL - 1);
  localparam logic [Y_BITS-1:0] V_LAST     = Y_BITS'(V_TOTAL - 1);
  localparam logic [X_BITS-1:0] H_ACT_X    = X_BITS'(H_ACTIVE);
  localparam logic [Y_BITS-1:0] V_ACT_Y    = Y_BITS'(V_ACTIVE);
  localparam logic [X_BITS-1:0] HS_FIRST_X = X_BITS'(H_ACTIVE + H_FP);
  localparam logic [X_BITS-1:0] HS_LAST_X  = X_BITS'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_BITS-1:0] VS_FIRST_Y = Y_BITS'(V_ACTIVE + V_FP);
  localparam logic [Y_BITS-1:0] VS_LAST_Y  = Y_BITS'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam int CNT_W = (PWR_DELAY > 1) ? $clog2(PWR_DELAY) : 1;
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(PWR_DELAY - 1);

  typedef enum logic [2:0] {
    OFF, VDD_UP, DISP_UP, RUN, BL_DOWN, DISP_DOWN
  } pwr_state_t;

  pwr_state_t       state, state_nxt;
  logic             enable_q;
  logic [CNT_W-1:0] dly_cnt;
  logic             dly_done;
  logic             stay_run;
  logic             load_shadow;

  function automatic logic [7:0] expand_comp(input logic [BPC-1:0] c);
    logic [7:0] w;
    w = 8'(c);
    return w << (8 - BPC);
  endfunction

  assign dly_done = (dly_cnt == '0);

  // Enable is registered once before the FSM sees it
  always_ff @(posedge tft_clk) begin
    if (!rstb) begin
      state    <= OFF;
      enable_q <= 1'b0;
      dly_cnt  <= '0;
    end else begin
      enable_q <= enable;
      state    <= state_nxt;
      if (state_nxt != state)
        dly_cnt <= DLY_LOAD;
      else if (!dly_done)
        dly_cnt <= dly_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OFF:       if (enable_q) state_nxt = VDD_UP;
      VDD_UP:    if (!enable_q) state_nxt = DISP_DOWN;
                 else if (dly_done) state_nxt = DISP_UP;
      DISP_UP:   if (!enable_q) state_nxt = DISP_DOWN;
                 else if (dly_done) state_nxt = RUN;
      RUN:       if (!enable_q) state_nxt = BL_DOWN;
      BL_DOWN:   if (dly_done) state_nxt = DISP_DOWN;
      DISP_DOWN: if (dly_done) state_nxt = OFF;
      default:   state_nxt = OFF;
    endcase
  end

  // Power pins are decoded from the next state so they switch with the state register
  always_ff @(posedge tft_clk) begin
    if (!rstb) begin
      tft_vdd       <= 1'b0;
      tft_display   <= 1'b0;
      tft_backlight <= 1'b0;
      running       <= 1'b0;
    end else begin
      tft_vdd       <= (state_nxt != OFF);
      tft_display   <= (state_nxt == DISP_UP) || (state_nxt == RUN) || (state_nxt == BL_DOWN);
      tft_backlight <= (state_nxt == RUN);
      running       <= (state_nxt == RUN);
    end
  end

  assign stay_run  = running && (state_nxt == RUN);
  assign new_frame = running && (x == H_LAST) && (y == V_LAST);

  always_ff @(posedge tft_clk) begin
    if (!rstb || !stay_run) begin
      x <= '0;
      y <= '0;
    end else if (x == H_LAST) begin
      x <= '0;
      y <= (y == V_LAST) ? '0 : y + Y_BITS'(1);
    end else begin
      x <= x + X_BITS'(1);
    end
  end

  // Shadow copies: refreshed on RUN entry and on the frame's last pixel only
  logic [NUM_RECTS-1:0]        sh_en;
  logic [NUM_RECTS*X_BITS-1:0] sh_x, sh_w;
  logic [NUM_RECTS*Y_BITS-1:0] sh_y, sh_h;
  logic [NUM_RECTS*3*BPC-1:0]  sh_color;
  logic [3*BPC-1:0]            sh_bg;

  assign load_shadow = (state_nxt == RUN) && (!running || new_frame);

  always_ff @(posedge tft_clk) begin
    if (!rstb) begin
      sh_en    <= '0;
      sh_x     <= '0;
      sh_w     <= '0;
      sh_y     <= '0;
      sh_h     <= '0;
      sh_color <= '0;
      sh_bg    <= '0;
    end else if (load_shadow) begin
      sh_en    <= rect_en;
      sh_x     <= rect_x;
      sh_w     <= rect_w;
      sh_y     <= rect_y;
      sh_h     <= rect_h;
      sh_color <= rect_color;
      sh_bg    <= bg_color;
    end
  end

  // Stage p0: timing decode and compositing on the live counters
  logic              vld_p0, hsync_p0, vsync_p0;
  logic [3*BPC-1:0]  pix_p0;
  logic [X_BITS-1:0] rx, rw;
  logic [Y_BITS-1:0] ry, rh;
  logic [X_BITS:0]   x_end;
  logic [Y_BITS:0]   y_end;

  assign vld_p0   = running && (x < H_ACT_X) && (y < V_ACT_Y);
  assign hsync_p0 = running && (x >= HS_FIRST_X) && (x <= HS_LAST_X);
  assign vsync_p0 = running && (y >= VS_FIRST_Y) && (y <= VS_LAST_Y);

  // Scanning from the highest index down lets the lowest-index hit win
  always_comb begin
    pix_p0 = sh_bg;
    rx     = '0;
    rw     = '0;
    ry     = '0;
    rh     = '0;
    x_end  = '0;
    y_end  = '0;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      rx    = sh_x[i*X_BITS +: X_BITS];
      rw    = sh_w[i*X_BITS +: X_BITS];
      ry    = sh_y[i*Y_BITS +: Y_BITS];
      rh    = sh_h[i*Y_BITS +: Y_BITS];
      x_end = {1'b0, rx} + {1'b0, rw};
      y_end = {1'b0, ry} + {1'b0, rh};
      if (sh_en[i] && (x >= rx) && ({1'b0, x} < x_end) &&
          (y >= ry) && ({1'b0, y} < y_end))
        pix_p0 = sh_color[i*3*BPC +: 3*BPC];
    end
  end

  // Stage p1: single aligned output register for all pixel-side pins
  logic       vld_p1, hsync_n_p1, vsync_n_p1;
  logic [7:0] red_p1, green_p1, blue_p1;

  always_ff @(posedge tft_clk) begin
    if (!rstb) begin
      vld_p1     <= 1'b0;
      hsync_n_p1 <= 1'b1;
      vsync_n_p1 <= 1'b1;
      red_p1     <= '0;
      green_p1   <= '0;
      blue_p1    <= '0;
    end else begin
      vld_p1     <= vld_p0;
      hsync_n_p1 <= !hsync_p0;
      vsync_n_p1 <= !vsync_p0;
      red_p1     <= vld_p0 ? expand_comp(pix_p0[2*BPC +: BPC]) : 8'h00;
      green_p1   <= vld_p0 ? expand_comp(pix_p0[BPC +: BPC])   : 8'h00;
      blue_p1    <= vld_p0 ? expand_comp(pix_p0[0 +: BPC])     : 8'h00;
    end
  end

  assign tft_data_ena = vld_p1;
  assign tft_hsync_n  = hsync_n_p1;
  assign tft_vsync_n  = vsync_n_p1;
  assign tft_red      = red_p1;
  assign tft_green    = green_p1;
  assign tft_blue     = blue_p1;

endmodule

// File: tb/tb_tft_raster_engine.sv
// Directed bench for tft_raster_engine on a small raster: power sequencing,
// sync placement, compositing priority, tear-free updates, boundaries and reset.
module tb_tft_raster_engine;

  localparam int HA = 20, HFP = 2, HS = 3, HB = 2;
  localparam int VA = 20, VFP = 2, VS = 2, VB = 2;
  localparam int XB = 5, YB = 5, BPC = 3, NR = 2, PD = 4;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FT = HT * VT;

  logic               tft_clk = 1'b0;
  logic               rstb, enable;
  logic [NR-1:0]      rect_en;
  logic [NR*XB-1:0]   rect_x, rect_w;
  logic [NR*YB-1:0]   rect_y, rect_h;
  logic [NR*3*BPC-1:0] rect_color;
  logic [3*BPC-1:0]   bg_color;
  logic               tft_vdd, tft_display, tft_backlight;
  logic               tft_data_ena, tft_hsync_n, tft_vsync_n;
  logic [7:0]         tft_red, tft_green, tft_blue;
  logic [XB-1:0]      x;
  logic [YB-1:0]      y;
  logic               new_frame, running;

  tft_raster_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .X_BITS(XB), .Y_BITS(YB), .BPC(BPC), .NUM_RECTS(NR), .PWR_DELAY(PD)
  ) dut (
    .tft_clk(tft_clk), .rstb(rstb), .enable(enable),
    .rect_en(rect_en), .rect_x(rect_x), .rect_w(rect_w),
    .rect_y(rect_y), .rect_h(rect_h), .rect_color(rect_color),
    .bg_color(bg_color),
    .tft_vdd(tft_vdd), .tft_display(tft_display), .tft_backlight(tft_backlight),
    .tft_data_ena(tft_data_ena), .tft_hsync_n(tft_hsync_n), .tft_vsync_n(tft_vsync_n),
    .tft_red(tft_red), .tft_green(tft_green), .tft_blue(tft_blue),
    .x(x), .y(y), .new_frame(new_frame), .running(running)
  );

  always #5 tft_clk = ~tft_clk;

  typedef struct {
    int de;
    int hs_n;
    int vs_n;
    int rgb;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   now   = 0;
  int   t0    = 0;
  int   base  = 0;

  task automatic tick();
    @(posedge tft_clk);
    #1;
    now++;
  endtask

  task automatic wait_until(input int t);
    while (now < t) tick();
  endtask

  function automatic int slot(input int f, input int px, input int py);
    return t0 + f * FT + py * HT + px;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_power(input string tag, input int vdd, input int disp, input int bl);
    chk({tag, ".vdd"},  32'(tft_vdd),       vdd);
    chk({tag, ".disp"}, 32'(tft_display),   disp);
    chk({tag, ".bl"},   32'(tft_backlight), bl);
  endtask

  // Pixel (px,py) of frame f is current at its slot; its outputs appear one tick later
  task automatic pix(input string tag, input int f, input int px, input int py,
                     input int de, input int hs_n, input int vs_n, input int rgb);
    exp_t e;
    wait_until(slot(f, px, py));
    chk({tag, ".x"}, 32'(x), px);
    chk({tag, ".y"}, 32'(y), py);
    e.de = de; e.hs_n = hs_n; e.vs_n = vs_n; e.rgb = rgb;
    sb_q.push_back(e);
    tick();
    e = sb_q.pop_front();
    chk({tag, ".de"},  32'(tft_data_ena), e.de);
    chk({tag, ".hs"},  32'(tft_hsync_n),  e.hs_n);
    chk({tag, ".vs"},  32'(tft_vsync_n),  e.vs_n);
    chk({tag, ".rgb"}, 32'({tft_red, tft_green, tft_blue}), e.rgb);
  endtask

  localparam int BG   = 32'hE06000;
  localparam int BLUE = 32'h0000E0;
  localparam int RED  = 32'hE00000;

  initial begin
    rstb       = 1'b0;
    enable     = 1'b0;
    rect_en    = 2'b11;
    rect_x     = {5'd12, 5'd10};
    rect_w     = {5'd5,  5'd5};
    rect_y     = {5'd12, 5'd10};
    rect_h     = {5'd5,  5'd5};
    rect_color = {9'o700, 9'o007};
    bg_color   = 9'o730;
    tick();
    tick();
    chk_power("rst", 0, 0, 0);
    chk("rst.run", 32'(running), 0);
    chk("rst.de",  32'(tft_data_ena), 0);
    chk("rst.hs",  32'(tft_hsync_n), 1);
    chk("rst.vs",  32'(tft_vsync_n), 1);
    chk("rst.x",   32'(x), 0);
    chk("rst.y",   32'(y), 0);
    chk("rst.rgb", 32'({tft_red, tft_green, tft_blue}), 0);
    chk("rst.nf",  32'(new_frame), 0);

    // Power-up: edge 0 samples enable
    rstb   = 1'b1;
    enable = 1'b1;
    base   = now;
    tick();
    chk_power("up.e0", 0, 0, 0);
    tick();
    chk_power("up.e1", 1, 0, 0);
    wait_until(base + 5);
    chk_power("up.e4", 1, 0, 0);
    tick();
    chk_power("up.e5", 1, 1, 0);
    wait_until(base + 9);
    chk_power("up.e8", 1, 1, 0);
    chk("up.e8.run", 32'(running), 0);
    chk("up.e8.x",   32'(x), 0);
    tick();
    chk_power("up.e9", 1, 1, 1);
    chk("up.e9.run", 32'(running), 1);
    t0 = now;

    // Frame 0: initial rectangles, then an input change that must stay hidden
    pix("f0.0_0",   0, 0, 0,   1, 1, 1, BG);
    pix("f0.10_10", 0, 10, 10, 1, 1, 1, BLUE);
    pix("f0.12_12", 0, 12, 12, 1, 1, 1, BLUE);
    rect_x[4:0]  = 5'd2;
    rect_x[9:5]  = 5'd15;
    rect_w[9:5]  = 5'd30;
    rect_y[9:5]  = 5'd0;
    rect_h[9:5]  = 5'd20;
    pix("f0.3_14",  0, 3, 14,  1, 1, 1, BG);
    pix("f0.14_14", 0, 14, 14, 1, 1, 1, BLUE);
    pix("f0.15_15", 0, 15, 15, 1, 1, 1, RED);
    pix("f0.16_16", 0, 16, 16, 1, 1, 1, RED);
    pix("f0.17_16", 0, 17, 16, 1, 1, 1, BG);
    pix("f0.hs21",  0, 21, 17, 0, 1, 1, 0);
    pix("f0.hs22",  0, 22, 17, 0, 0, 1, 0);
    pix("f0.hs24",  0, 24, 17, 0, 0, 1, 0);
    pix("f0.hs25",  0, 25, 17, 0, 1, 1, 0);
    pix("f0.blank", 0, 20, 18, 0, 1, 1, 0);
    pix("f0.vs21",  0, 0, 21,  0, 1, 1, 0);
    pix("f0.vs22",  0, 0, 22,  0, 1, 0, 0);
    pix("f0.vs23",  0, 5, 23,  0, 1, 0, 0);
    pix("f0.vs24",  0, 0, 24,  0, 1, 1, 0);
    wait_until(slot(0, 25, 25));
    chk("f0.nf_pre", 32'(new_frame), 0);
    wait_until(slot(0, 26, 25));
    chk("f0.nf", 32'(new_frame), 1);

    // Frame 1: moved rect0, wide rect1 clipped at the active edge
    pix("f1.0_0",   1, 0, 0,   1, 1, 1, BG);
    pix("f1.15_0",  1, 15, 0,  1, 1, 1, RED);
    pix("f1.19_0",  1, 19, 0,  1, 1, 1, RED);
    pix("f1.10_10", 1, 10, 10, 1, 1, 1, BG);
    pix("f1.3_12",  1, 3, 12,  1, 1, 1, BLUE);
    pix("f1.14_12", 1, 14, 12, 1, 1, 1, BG);
    pix("f1.19_12", 1, 19, 12, 1, 1, 1, RED);
    pix("f1.20_12", 1, 20, 12, 0, 1, 1, 0);
    rect_w[4:0] = 5'd0;

    // Frame 2: zero-width rect0 is never drawn
    pix("f2.2_10",  2, 2, 10,  1, 1, 1, BG);
    pix("f2.3_12",  2, 3, 12,  1, 1, 1, BG);
    pix("f2.19_12", 2, 19, 12, 1, 1, 1, RED);

    // Power-down from RUN
    wait_until(slot(2, 5, 13));
    enable = 1'b0;
    base   = now;
    tick();
    chk_power("dn.e0", 1, 1, 1);
    chk("dn.e0.run", 32'(running), 1);
    tick();
    chk_power("dn.e1", 1, 1, 0);
    chk("dn.e1.run", 32'(running), 0);
    chk("dn.e1.x",   32'(x), 0);
    chk("dn.e1.y",   32'(y), 0);
    chk("dn.e1.de",  32'(tft_data_ena), 1);
    chk("dn.e1.rgb", 32'({tft_red, tft_green, tft_blue}), BG);
    tick();
    chk("dn.e2.de",  32'(tft_data_ena), 0);
    chk("dn.e2.rgb", 32'({tft_red, tft_green, tft_blue}), 0);
    wait_until(base + 5);
    chk_power("dn.e4", 1, 1, 0);
    tick();
    chk_power("dn.e5", 1, 0, 0);
    wait_until(base + 9);
    chk_power("dn.e8", 1, 0, 0);
    tick();
    chk_power("dn.e9", 0, 0, 0);

    // Re-enable, then reset in the middle of a sync region
    enable = 1'b1;
    base   = now;
    wait_until(base + 10);
    chk("re.run", 32'(running), 1);
    chk_power("re", 1, 1, 1);
    t0 = now;
    wait_until(slot(0, 23, 22));
    rstb = 1'b0;
    tick();
    chk_power("mrst", 0, 0, 0);
    chk("mrst.run", 32'(running), 0);
    chk("mrst.x",   32'(x), 0);
    chk("mrst.y",   32'(y), 0);
    chk("mrst.hs",  32'(tft_hsync_n), 1);
    chk("mrst.vs",  32'(tft_vsync_n), 1);
    chk("mrst.de",  32'(tft_data_ena), 0);
    chk("mrst.rgb", 32'({tft_red, tft_green, tft_blue}), 0);
    rstb = 1'b1;
    base = now;
    tick();
    chk_power("rs.e0", 0, 0, 0);
    tick();
    chk_power("rs.e1", 1, 0, 0);
    wait_until(base + 10);
    chk("rs.run", 32'(running), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
